instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Initiator side of the instruction-memory interface: owns the PC, drives the combinational memory address, and captures the returned word into the IF/ID pipeline register.
- Supports 32-bit memories (one access per instruction) and 16-bit memories (two accesses, upper half-word first, big-endian concatenation).
- Sits between the hazard/branch logic in ID and the instruction memory.

Parameters:
- MEM_WIDTH, 32, memory word width; only 16 or 32 are legal, any other value is an elaboration error.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit: freeze PC, FSM, hold register and IF/ID.
- flush  in  1  invalidate the IF/ID entry.
- redirect  in  1  taken branch/jump from ID.
- redirect_target  in  32  branch/jump target; bits [1:0] are forced to 0.
- mem_address  out  32  byte address to the instruction memory; combinational from state.
- mem_rdata  in  MEM_WIDTH  memory read data, valid in the same cycle as mem_address.
- if_id_ir  out  32  fetched instruction.
- if_id_pc_plus4  out  32  PC+4 of the fetched instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_busy  out  1  high while in FETCH_LO (16-bit mode only; tied 0 when MEM_WIDTH=32).

Behaviour:
- Reset values:
  - pc=RESET_PC, state=FETCH_HI
  - hold=0, pending_valid=0, pending_target=0
  - if_id_ir=32'h0 (NOP), if_id_pc_plus4=0, if_id_valid=0
- Priority for IF/ID: reset > flush > stall > normal load. Flush writes ir=0 and valid=0 even while stalled; it does not touch pc, state or pending.
- Stall freezes pc, state, hold and IF/ID. mem_address stays stable.
- Redirect capture:
  - When redirect=1 and pending_valid=0, record pending_valid=1 and pending_target=redirect_target&~3. This happens regardless of stall.
  - A repeated assertion while pending_valid=1 is ignored (idempotent).
- Completion boundary: the cycle in which an instruction is loaded into IF/ID.
- Next PC at completion:
  - If (pending_valid | redirect): next pc = pending_valid ? pending_target : redirect_target&~3, and pending_valid is cleared.
  - Otherwise: next pc = pc+4, wrapping modulo 2^32.
  - The in-flight instruction always completes first, which implements the MIPS delay slot.
- MEM_WIDTH=32:
  - mem_address=pc.
  - Each non-stalled cycle is a completion: if_id_ir<=mem_rdata, if_id_pc_plus4<=pc+4, if_id_valid<=1.
  - Latency: address to IF/ID is 1 cycle; throughput is 1 instruction per cycle.
- MEM_WIDTH=16, two-state FSM:
  - FETCH_HI:
    - mem_address=pc; hold<=mem_rdata.
    - IF/ID loads a bubble (ir=0, valid=0).
    - Next state FETCH_LO.
  - FETCH_LO:
    - mem_address=pc+2.
    - Completion: if_id_ir<={hold,mem_rdata}, pc_plus4<=pc+4, valid<=1.
    - Next state FETCH_HI.
  - Throughput is 1 instruction per 2 cycles; the bubble in FETCH_HI tells ID to ignore it.
  - A redirect arriving in FETCH_HI stays pending until the FETCH_LO completion.
- Boundary cases:
  - Reset during FETCH_LO discards the partial half-word and returns to FETCH_HI at RESET_PC.
  - Stall in FETCH_LO holds the hold register until release.
  - Stall together with flush: IF/ID is cleared, everything else is frozen.
  - pc=32'hFFFF_FFFC: pc_plus4=0 and next pc=0.
  - A misaligned redirect_target is silently aligned.

Decomposition:
- Shared package mips_pkg holds:
  - INSTR_WIDTH=32
  - NOP_INSTR=32'h0000_0000
  - fetch_state_t enum {FETCH_HI, FETCH_LO}
  - the PC_INCR=4 constant
- One sub-module is natural: if_id_register. It holds ir, pc_plus4 and valid, has inputs flush/stall/load, and is reused by later pipeline-register work.
- The FSM and PC logic stay in instruction_fetch; for MEM_WIDTH=32 the FSM is generated out.

Test Plan:
1. MEM_WIDTH=32, RESET_PC=0, memory words 0x11,0x22,0x33, run 3 cycles after reset -> mem_address 0,4,8; IF/ID (ir,pc_plus4,valid) = (0x11,4,1),(0x22,8,1),(0x33,12,1).
2. MEM_WIDTH=32, redirect=1 target=0x43 while pc=8 -> word at 8 loads as the delay slot; next mem_address=0x40; pending clears.
3. MEM_WIDTH=16, half-words 0x1234,0x5678 at 0,2 -> cycle 1 valid=0, fetch_busy=1; cycle 2 if_id_ir=0x12345678, pc_plus4=4; next mem_address=4.
4. MEM_WIDTH=16, redirect pulse to 0x100 in FETCH_HI at pc=8 -> instruction at 8 completes in FETCH_LO; then mem_address=0x100.
5. stall=1 for 3 cycles with flush=1 on the 2nd -> pc/mem_address constant; IF/ID unchanged until flush, then ir=0, valid=0; after release fetch resumes at the same pc.
6. reset asserted in FETCH_LO at pc=0x20 -> next cycle mem_address=RESET_PC, state FETCH_HI, all IF/ID fields 0, pending cleared.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction width, NOP encoding, PC step and fetch FSM states.
package mips_pkg;

    localparam int          INSTR_WIDTH = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [31:0] PC_INCR     = 32'd4;

    typedef enum logic {
        FETCH_HI = 1'b0,
        FETCH_LO = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: priority reset > flush > stall > load.
// A non-stalled cycle without load inserts a bubble (ir=NOP, valid=0) and keeps pc_plus4.
module if_id_register
    import mips_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   stall_i,
    input  logic                   load_i,
    input  logic [INSTR_WIDTH-1:0] ir_i,
    input  logic [31:0]            pc_plus4_i,
    output logic [INSTR_WIDTH-1:0] ir_o,
    output logic [31:0]            pc_plus4_o,
    output logic                   valid_o
);

    logic [INSTR_WIDTH-1:0] ir_q;
    logic [31:0]            pc_plus4_q;
    logic                   valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q       <= NOP_INSTR;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            ir_q    <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (!stall_i) begin
            if (load_i) begin
                ir_q       <= ir_i;
                pc_plus4_q <= pc_plus4_i;
                valid_q    <= 1'b1;
            end else begin
                ir_q    <= NOP_INSTR;
                valid_q <= 1'b0;
            end
        end
    end

    assign ir_o       = ir_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the memory address and fills IF/ID.
// With a 16-bit memory each instruction takes two accesses, upper half-word first.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FETCH_HI | address pc, capture upper half-word into hold, IF/ID bubble
//   FETCH_LO | address pc+2, complete {hold, rdata} into IF/ID
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int          MEM_WIDTH = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   redirect,
    input  logic [31:0]            redirect_target,
    output logic [31:0]            mem_address,
    input  logic [MEM_WIDTH-1:0]   mem_rdata,
    output logic [INSTR_WIDTH-1:0] if_id_ir,
    output logic [31:0]            if_id_pc_plus4,
    output logic                   if_id_valid,
    output logic                   fetch_busy
);

    logic [31:0]            pc_q, pc_d;
    logic                   pending_valid_q, pending_valid_d;
    logic [31:0]            pending_target_q, pending_target_d;
    logic                   load_slot;
    logic                   complete;
    logic [INSTR_WIDTH-1:0] fetched_word;
    logic [31:0]            aligned_target;
    logic [31:0]            pc_plus4;

    assign aligned_target = redirect_target & ~32'h3;
    assign pc_plus4       = pc_q + PC_INCR;
    assign complete       = load_slot && !stall;

    generate
        if (MEM_WIDTH != 16 && MEM_WIDTH != 32) begin : g_bad_width
            $error("instruction_fetch: MEM_WIDTH must be 16 or 32");
        end

        if (MEM_WIDTH == 16) begin : g_fsm16
            fetch_state_t          state_q;
            logic [MEM_WIDTH-1:0]  hold_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= FETCH_HI;
                    hold_q  <= '0;
                end else if (!stall) begin
                    if (state_q == FETCH_HI) begin
                        hold_q  <= mem_rdata;
                        state_q <= FETCH_LO;
                    end else begin
                        state_q <= FETCH_HI;
                    end
                end
            end

            assign load_slot    = (state_q == FETCH_LO);
            assign fetched_word = {hold_q, mem_rdata};
            assign mem_address  = load_slot ? (pc_q + 32'd2) : pc_q;
            assign fetch_busy   = load_slot;
        end else begin : g_fsm32
            assign load_slot    = 1'b1;
            assign fetched_word = mem_rdata;
            assign mem_address  = pc_q;
            assign fetch_busy   = 1'b0;
        end
    endgenerate

    // The in-flight instruction always completes before a redirect takes effect (delay slot).
    always_comb begin
        pc_d             = pc_q;
        pending_valid_d  = pending_valid_q;
        pending_target_d = pending_target_q;
        if (redirect && !pending_valid_q) begin
            pending_valid_d  = 1'b1;
            pending_target_d = aligned_target;
        end
        if (complete) begin
            pending_valid_d = 1'b0;
            if (pending_valid_q) begin
                pc_d = pending_target_q;
            end else if (redirect) begin
                pc_d = aligned_target;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q             <= RESET_PC;
            pending_valid_q  <= 1'b0;
            pending_target_q <= 32'h0;
        end else begin
            pc_q             <= pc_d;
            pending_valid_q  <= pending_valid_d;
            pending_target_q <= pending_target_d;
        end
    end

    if_id_register u_if_id (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush),
        .stall_i    (stall),
        .load_i     (load_slot),
        .ir_i       (fetched_word),
        .pc_plus4_i (pc_plus4),
        .ir_o       (if_id_ir),
        .pc_plus4_o (if_id_pc_plus4),
        .valid_o    (if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: table-driven 32-bit vectors plus hand sequences for 16-bit mode.
module tb_instruction_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 32-bit instance
    logic        rst32, stall32, flush32, redir32;
    logic [31:0] tgt32, addr32, rdata32, ir32, pc4_32;
    logic        v32, busy32;
    logic [31:0] mem32 [0:127];
    assign rdata32 = mem32[addr32[8:2]];

    instruction_fetch #(.MEM_WIDTH(32), .RESET_PC(32'h0)) dut32 (
        .clk(clk), .reset(rst32), .stall(stall32), .flush(flush32),
        .redirect(redir32), .redirect_target(tgt32), .mem_address(addr32),
        .mem_rdata(rdata32), .if_id_ir(ir32), .if_id_pc_plus4(pc4_32),
        .if_id_valid(v32), .fetch_busy(busy32)
    );

    // 16-bit instance
    logic        rst16, stall16, flush16, redir16;
    logic [31:0] tgt16, addr16, ir16, pc4_16;
    logic [15:0] rdata16;
    logic        v16, busy16;
    logic [15:0] mem16 [0:255];
    assign rdata16 = mem16[addr16[8:1]];

    instruction_fetch #(.MEM_WIDTH(16), .RESET_PC(32'h0)) dut16 (
        .clk(clk), .reset(rst16), .stall(stall16), .flush(flush16),
        .redirect(redir16), .redirect_target(tgt16), .mem_address(addr16),
        .mem_rdata(rdata16), .if_id_ir(ir16), .if_id_pc_plus4(pc4_16),
        .if_id_valid(v16), .fetch_busy(busy16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] e_addr;
        logic [31:0] e_ir;
        logic [31:0] e_pc4;
        logic        e_v;
    } vec_t;

    vec_t vecs [15];

    initial begin
        for (int i = 0; i < 128; i++) mem32[i] = 32'hC000_0000 | (i << 2);
        mem32[0] = 32'h11; mem32[1] = 32'h22; mem32[2] = 32'h33;
        for (int i = 0; i < 256; i++) mem16[i] = 16'hB000 | 16'(i);
        mem16[0] = 16'h1234; mem16[1] = 16'h5678;

        //            stall flush redir tgt           addr          ir            pc4           v
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h11,       32'h4,        1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h22,       32'h8,        1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h43,       32'h8,        32'h33,       32'hC,        1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h40,       32'hC000_0040, 32'h44,      1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h44,       32'hC000_0040, 32'h44,      1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h44,       32'h0,        32'h44,       1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h44,       32'h0,        32'h44,       1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h44,       32'hC000_0044, 32'h48,      1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h81,       32'h48,       32'hC000_0044, 32'h48,      1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h200,      32'h48,       32'hC000_0048, 32'h4C,      1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h80,       32'hC000_0080, 32'h84,      1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h84,       32'h0,        32'h84,       1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h88,      32'hC000_0088, 32'h8C,      1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'hFFFF_FFFC, 32'hC000_01FC, 32'h0,      1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h11,       32'h4,        1'b1};

        rst32 = 1'b1; stall32 = 1'b0; flush32 = 1'b0; redir32 = 1'b0; tgt32 = 32'h0;
        rst16 = 1'b1; stall16 = 1'b0; flush16 = 1'b0; redir16 = 1'b0; tgt16 = 32'h0;

        cyc(); cyc();
        chk("rst32_addr", addr32, 32'h0);
        chk("rst32_ir", ir32, 32'h0);
        chk("rst32_pc4", pc4_32, 32'h0);
        chk("rst32_valid", {31'h0, v32}, 32'h0);
        chk("rst32_busy", {31'h0, busy32}, 32'h0);

        @(negedge clk);
        rst32 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            stall32 = vecs[i].stall; flush32 = vecs[i].flush;
            redir32 = vecs[i].redir; tgt32 = vecs[i].tgt;
            #1;
            chk($sformatf("v%0d_addr", i), addr32, vecs[i].e_addr);
            cyc();
            chk($sformatf("v%0d_ir", i), ir32, vecs[i].e_ir);
            chk($sformatf("v%0d_pc4", i), pc4_32, vecs[i].e_pc4);
            chk($sformatf("v%0d_valid", i), {31'h0, v32}, {31'h0, vecs[i].e_v});
        end
        @(negedge clk);
        stall32 = 1'b0; flush32 = 1'b0; redir32 = 1'b0;

        // 16-bit: two accesses per instruction, big-endian concatenation
        rst16 = 1'b0;
        #1;
        chk("h_addr0", addr16, 32'h0);
        chk("h_busy0", {31'h0, busy16}, 32'h0);
        cyc();
        chk("h_valid1", {31'h0, v16}, 32'h0);
        chk("h_busy1", {31'h0, busy16}, 32'h1);
        chk("h_addr1", addr16, 32'h2);
        cyc();
        chk("h_ir2", ir16, 32'h1234_5678);
        chk("h_pc4_2", pc4_16, 32'h4);
        chk("h_valid2", {31'h0, v16}, 32'h1);
        chk("h_addr2", addr16, 32'h4);
        chk("h_busy2", {31'h0, busy16}, 32'h0);
        cyc(); cyc();
        chk("h_ir4", ir16, 32'hB002_B003);
        chk("h_addr4", addr16, 32'h8);

        // redirect pulse in FETCH_HI: instruction at 8 completes first
        @(negedge clk); redir16 = 1'b1; tgt16 = 32'h100;
        cyc();
        chk("r_addr_lo", addr16, 32'hA);
        chk("r_valid_hi", {31'h0, v16}, 32'h0);
        @(negedge clk); redir16 = 1'b0;
        cyc();
        chk("r_ir_slot", ir16, 32'hB004_B005);
        chk("r_pc4_slot", pc4_16, 32'hC);
        chk("r_addr_tgt", addr16, 32'h100);
        cyc();
        chk("s_addr_lo", addr16, 32'h102);

        // stall in FETCH_LO with flush on the 2nd cycle; hold must survive
        @(negedge clk); stall16 = 1'b1;
        cyc();
        chk("s1_addr", addr16, 32'h102);
        chk("s1_busy", {31'h0, busy16}, 32'h1);
        chk("s1_pc4", pc4_16, 32'hC);
        @(negedge clk); flush16 = 1'b1;
        cyc();
        chk("s2_addr", addr16, 32'h102);
        chk("s2_ir", ir16, 32'h0);
        chk("s2_valid", {31'h0, v16}, 32'h0);
        @(negedge clk); flush16 = 1'b0;
        cyc();
        chk("s3_addr", addr16, 32'h102);
        @(negedge clk); stall16 = 1'b0;
        cyc();
        chk("s4_ir", ir16, 32'hB080_B081);
        chk("s4_pc4", pc4_16, 32'h104);
        chk("s4_valid", {31'h0, v16}, 32'h1);
        chk("s4_addr", addr16, 32'h104);

        // misaligned redirect to 0x21, then reset mid-instruction with a pending redirect
        @(negedge clk); redir16 = 1'b1; tgt16 = 32'h21;
        cyc();
        @(negedge clk); redir16 = 1'b0;
        cyc();
        chk("m_ir", ir16, 32'hB082_B083);
        chk("m_addr", addr16, 32'h20);
        @(negedge clk); redir16 = 1'b1; tgt16 = 32'h300;
        cyc();
        chk("x_addr_lo", addr16, 32'h22);
        @(negedge clk); redir16 = 1'b0; rst16 = 1'b1;
        cyc();
        chk("x_addr", addr16, 32'h0);
        chk("x_busy", {31'h0, busy16}, 32'h0);
        chk("x_ir", ir16, 32'h0);
        chk("x_pc4", pc4_16, 32'h0);
        chk("x_valid", {31'h0, v16}, 32'h0);
        @(negedge clk); rst16 = 1'b0;
        cyc(); cyc();
        chk("x_ir_after", ir16, 32'h1234_5678);
        chk("x_addr_after", addr16, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish within 20000 time units");
        $fatal(1, "timeout");
    end

endmodule
